// File: rtl/branch_resolve_scheduler_if.sv
// Branch issue/resolve bundle between the issue slots and the shared resolver.
// Latency and backpressure are set by the scheduler; req_ready is the per-slot grant.
interface branch_resolve_scheduler_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic [TAG_W-1:0]   rob_head;
  logic               flush_in;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*TAG_W-1:0] req_tag;
  logic [5:0]         req_branch;
  logic [63:0]        req_op1;
  logic [63:0]        req_op2;
  logic [1:0]         req_pred;
  logic [63:0]        req_target;
  logic [63:0]        req_pc4;
  logic               res_valid;
  logic [TAG_W-1:0]   res_tag;
  logic               res_taken;
  logic               res_mispredict;
  logic [31:0]        redirect_pc;
  logic               busy;
  logic [CNT_W-1:0]   cnt_branches;
  logic [CNT_W-1:0]   cnt_mispred;

  modport master (
    output rob_head, flush_in, req_valid, req_tag, req_branch, req_op1, req_op2,
           req_pred, req_target, req_pc4,
    input  req_ready, res_valid, res_tag, res_taken, res_mispredict, redirect_pc,
           busy, cnt_branches, cnt_mispred
  );

  modport slave (
    input  rob_head, flush_in, req_valid, req_tag, req_branch, req_op1, req_op2,
           req_pred, req_target, req_pc4,
    output req_ready, res_valid, res_tag, res_taken, res_mispredict, redirect_pc,
           busy, cnt_branches, cnt_mispred
  );
endinterface

// File: rtl/branch_resolve_scheduler.sv
// Grants the oldest ready branch of two slots to one comparator; result 1 cycle after accept.
// No grants (req_ready=0) while a mispredict is visible, during FLUSH, on flush_in or rst.
module branch_resolve_scheduler #(
  parameter int TAG_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                       clk,
  input logic                       rst,
  branch_resolve_scheduler_if.slave bus
);
  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  count_q, count_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_taken_q, res_taken_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] cnt_branches_q, cnt_branches_d;
  logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

  logic [TAG_W-1:0] age0, age1;
  logic             pick1, mis_now, grant_ok, accept, count_br;
  logic [1:0]       ready;

  // Ages are taken modulo 2^TAG_W relative to the ROB head; ties favour slot 0.
  always_comb begin
    age0     = bus.req_tag[0 +: TAG_W] - bus.rob_head;
    age1     = bus.req_tag[TAG_W +: TAG_W] - bus.rob_head;
    pick1    = bus.req_valid[1] & (~bus.req_valid[0] | (age1 < age0));
    mis_now  = res_valid_q & res_mispredict_q;
    grant_ok = ~rst & ~bus.flush_in & (state_q == IDLE) & ~mis_now;
    ready    = 2'b00;
    if (grant_ok && (bus.req_valid != 2'b00)) begin
      ready = pick1 ? 2'b10 : 2'b01;
    end
    accept   = |ready;
  end

  logic [TAG_W-1:0] sel_tag;
  logic [2:0]       sel_code;
  logic [31:0]      sel_op1, sel_op2, sel_target, sel_pc4;
  logic             sel_pred, sel_taken;

  always_comb begin
    sel_tag    = pick1 ? bus.req_tag[TAG_W +: TAG_W] : bus.req_tag[0 +: TAG_W];
    sel_code   = pick1 ? bus.req_branch[5:3]    : bus.req_branch[2:0];
    sel_op1    = pick1 ? bus.req_op1[63:32]     : bus.req_op1[31:0];
    sel_op2    = pick1 ? bus.req_op2[63:32]     : bus.req_op2[31:0];
    sel_target = pick1 ? bus.req_target[63:32]  : bus.req_target[31:0];
    sel_pc4    = pick1 ? bus.req_pc4[63:32]     : bus.req_pc4[31:0];
    sel_pred   = pick1 ? bus.req_pred[1]        : bus.req_pred[0];
    case (sel_code)
      3'b001:  sel_taken = (sel_op1 == sel_op2);
      3'b010:  sel_taken = (sel_op1 != sel_op2);
      3'b011:  sel_taken = (sel_op1 <  sel_op2);
      3'b100:  sel_taken = (sel_op1 >  sel_op2);
      3'b101:  sel_taken = (sel_op1 <= sel_op2);
      3'b110:  sel_taken = (sel_op1 >= sel_op2);
      default: sel_taken = 1'b0;
    endcase
  end

  always_comb begin
    res_valid_d      = accept;
    res_tag_d        = accept ? sel_tag : res_tag_q;
    res_taken_d      = accept ? sel_taken : res_taken_q;
    res_mispredict_d = accept ? (sel_taken != sel_pred) : res_mispredict_q;
    redirect_pc_d    = accept ? (sel_taken ? sel_target : sel_pc4) : redirect_pc_q;

    // A result visible in a flush_in cycle is squashed and not counted.
    count_br       = res_valid_q & ~bus.flush_in;
    cnt_branches_d = cnt_branches_q;
    cnt_mispred_d  = cnt_mispred_q;
    if (count_br && !(&cnt_branches_q)) cnt_branches_d = cnt_branches_q + CNT_W'(1);
    if (count_br && res_mispredict_q && !(&cnt_mispred_q)) begin
      cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
    end

    state_d = state_q;
    count_d = count_q;
    if (bus.flush_in) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mis_now) begin
            state_d = FLUSH;
            count_d = FC_W'(FLUSH_CYCLES);
          end
        end
        FLUSH: begin
          count_d = count_q - FC_W'(1);
          if (count_q == FC_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      count_q          <= '0;
      busy_q           <= 1'b0;
      res_valid_q      <= 1'b0;
      res_tag_q        <= '0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_branches_q   <= '0;
      cnt_mispred_q    <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      busy_q           <= busy_d;
      res_valid_q      <= res_valid_d;
      res_tag_q        <= res_tag_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      redirect_pc_q    <= redirect_pc_d;
      cnt_branches_q   <= cnt_branches_d;
      cnt_mispred_q    <= cnt_mispred_d;
    end
  end

  assign bus.req_ready      = ready;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_tag        = res_tag_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_mispredict = res_mispredict_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.busy           = busy_q;
  assign bus.cnt_branches   = cnt_branches_q;
  assign bus.cnt_mispred    = cnt_mispred_q;
endmodule
